// File: rtl/wash_if.sv
// Signal bundle between the wash sequencer and its surroundings: user
// controls, level sensors, phase-timer flags going in; phase-timer
// controls, actuators and status coming out.
interface wash_if;
   logic       start;
   logic [1:0] mode;
   logic       pause;
   logic       cancel;
   logic       lid_closed;
   logic       water_full;
   logic       water_empty;
   logic       soaked;
   logic       washed;
   logic       rinsed;
   logic       spun;
   logic       idle;
   logic       ready1;
   logic       ready2;
   logic       ready3;
   logic       soak;
   logic       wash;
   logic       rinse;
   logic       spin;
   logic       fill_valve;
   logic       drain_valve;
   logic       door_lock;
   logic       done;
   logic       fault;
   logic       paused;
   logic [3:0] state_o;

   // Environment side: drives user/sensor/timer inputs, observes controls.
   modport master (
      output start, mode, pause, cancel, lid_closed, water_full, water_empty,
             soaked, washed, rinsed, spun,
      input  idle, ready1, ready2, ready3, soak, wash, rinse, spin,
             fill_valve, drain_valve, door_lock, done, fault, paused, state_o
   );

   // Sequencer side.
   modport slave (
      input  start, mode, pause, cancel, lid_closed, water_full, water_empty,
             soaked, washed, rinsed, spun,
      output idle, ready1, ready2, ready3, soak, wash, rinse, spin,
             fill_valve, drain_valve, door_lock, done, fault, paused, state_o
   );
endinterface

// File: rtl/wash_sequencer.sv
// Washing machine cycle controller. Steps through fill/soak/wash/drain/
// fill/rinse/drain/spin, handles pause, cancel and a fill/drain watchdog.
// Every output is registered: the next output values are decoded from the
// next state (and the sampled pause condition) and clocked in together
// with the state, so nothing reaches the pins combinationally.
module wash_sequencer #(
   parameter int TMO_W         = 12,
   parameter int FILL_TIMEOUT  = 3000,
   parameter int DRAIN_TIMEOUT = 2000
) (
   input logic   clk,
   input logic   rst_n,
   wash_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_READY  = 4'd1,
      S_FILL1  = 4'd2,
      S_SOAK   = 4'd3,
      S_WASH   = 4'd4,
      S_DRAIN1 = 4'd5,
      S_FILL2  = 4'd6,
      S_RINSE  = 4'd7,
      S_DRAIN2 = 4'd8,
      S_SPIN   = 4'd9,
      S_DONE   = 4'd10,
      S_ABORT  = 4'd11,
      S_FAULT  = 4'd12
   } state_t;

   // State codes of the timed phases, in soak/wash/rinse/spin bit order.
   localparam logic [15:0] PHASE_CODES = {4'd9, 4'd7, 4'd4, 4'd3};

   state_t           state_reg, state_next;
   logic [1:0]       mode_reg, mode_next;
   logic [TMO_W-1:0] wd_reg, wd_next;
   logic             fill_st, drain_st, wd_expired, cancellable;

   logic             hold_next, idle_next, fill_next, drain_next, lock_next;
   logic             done_next, fault_next;
   logic [2:0]       ready_next, ready_reg;
   logic [3:0]       phase_next, phase_reg;
   logic             idle_reg, fill_reg, drain_reg, lock_reg;
   logic             done_reg, fault_reg, paused_reg;

   // Watchdog classification of the current state and expiry detection.
   always_comb begin
      fill_st     = (state_reg == S_FILL1) || (state_reg == S_FILL2);
      drain_st    = (state_reg == S_DRAIN1) || (state_reg == S_DRAIN2) ||
                    (state_reg == S_ABORT);
      wd_expired  = (fill_st  && (wd_reg == TMO_W'(FILL_TIMEOUT - 1))) ||
                    (drain_st && (wd_reg == TMO_W'(DRAIN_TIMEOUT - 1)));
      cancellable = (state_reg >= S_READY) && (state_reg <= S_SPIN);
   end

   // Next state with priority watchdog > cancel > normal advance; mode latch.
   always_comb begin
      state_next = state_reg;
      mode_next  = mode_reg;
      if (wd_expired) begin
         state_next = S_FAULT;
      end else if (bus.cancel && cancellable) begin
         state_next = S_ABORT;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.start && bus.lid_closed && (bus.mode != 2'b00)) begin
                  state_next = S_READY;
                  mode_next  = bus.mode;
               end
            end
            S_READY:  state_next = S_FILL1;
            S_FILL1:  if (bus.water_full)  state_next = S_SOAK;
            S_SOAK:   if (bus.soaked)      state_next = S_WASH;
            S_WASH:   if (bus.washed)      state_next = S_DRAIN1;
            S_DRAIN1: if (bus.water_empty) state_next = S_FILL2;
            S_FILL2:  if (bus.water_full)  state_next = S_RINSE;
            S_RINSE:  if (bus.rinsed)      state_next = S_DRAIN2;
            S_DRAIN2: if (bus.water_empty) state_next = S_SPIN;
            S_SPIN:   if (bus.spun)        state_next = S_DONE;
            S_DONE:   if (bus.start)       state_next = S_IDLE;
            S_ABORT:  if (bus.water_empty) state_next = S_IDLE;
            default:  state_next = state_reg;
         endcase
      end
      // Counter restarts on every state change and only runs while staying
      // in a fill, drain or abort state.
      if ((state_next == state_reg) && (fill_st || drain_st)) begin
         wd_next = wd_reg + TMO_W'(1);
      end else begin
         wd_next = '0;
      end
   end

   // Decode the output values that belong to the next state.
   always_comb begin
      hold_next  = ((state_next == S_SOAK) || (state_next == S_WASH) ||
                    (state_next == S_RINSE) || (state_next == S_SPIN)) &&
                   (bus.pause || !bus.lid_closed);
      idle_next  = (state_next == S_IDLE);
      fill_next  = (state_next == S_FILL1) || (state_next == S_FILL2);
      drain_next = (state_next == S_DRAIN1) || (state_next == S_DRAIN2) ||
                   (state_next == S_ABORT);
      lock_next  = ((state_next >= S_READY) && (state_next <= S_SPIN)) ||
                   (state_next == S_ABORT);
      done_next  = (state_next == S_DONE);
      fault_next = (state_next == S_FAULT);
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ready
         assign ready_next[gi] = (state_next == S_READY) &&
                                 (mode_next == 2'(gi + 1));
      end
      for (genvar gi = 0; gi < 4; gi++) begin : g_phase
         assign phase_next[gi] = (4'(state_next) == PHASE_CODES[gi*4 +: 4]) &&
                                 !hold_next;
      end
   endgenerate

   // State, latched mode and watchdog registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         mode_reg  <= 2'b01;
         wd_reg    <= '0;
      end else begin
         state_reg <= state_next;
         mode_reg  <= mode_next;
         wd_reg    <= wd_next;
      end
   end

   // Output registers; reset drops every actuator immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_reg   <= 1'b1;
         ready_reg  <= '0;
         phase_reg  <= '0;
         fill_reg   <= 1'b0;
         drain_reg  <= 1'b0;
         lock_reg   <= 1'b0;
         done_reg   <= 1'b0;
         fault_reg  <= 1'b0;
         paused_reg <= 1'b0;
      end else begin
         idle_reg   <= idle_next;
         ready_reg  <= ready_next;
         phase_reg  <= phase_next;
         fill_reg   <= fill_next;
         drain_reg  <= drain_next;
         lock_reg   <= lock_next;
         done_reg   <= done_next;
         fault_reg  <= fault_next;
         paused_reg <= hold_next;
      end
   end

   assign bus.idle        = idle_reg;
   assign bus.ready1      = ready_reg[0];
   assign bus.ready2      = ready_reg[1];
   assign bus.ready3      = ready_reg[2];
   assign bus.soak        = phase_reg[0];
   assign bus.wash        = phase_reg[1];
   assign bus.rinse       = phase_reg[2];
   assign bus.spin        = phase_reg[3];
   assign bus.fill_valve  = fill_reg;
   assign bus.drain_valve = drain_reg;
   assign bus.door_lock   = lock_reg;
   assign bus.done        = done_reg;
   assign bus.fault       = fault_reg;
   assign bus.paused      = paused_reg;
   assign bus.state_o     = state_reg;

endmodule

// File: tb/tb_wash_sequencer.sv
// Testbench for wash_sequencer: directed scenarios with literal checks plus
// a randomized run, all compared every cycle against a behavioural model.
module tb_wash_sequencer;
   localparam int FILL_T  = 3000;
   localparam int DRAIN_T = 2000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   wash_if bus();

   wash_sequencer #(
      .TMO_W(12),
      .FILL_TIMEOUT(FILL_T),
      .DRAIN_TIMEOUT(DRAIN_T)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- behavioural model ----------------
   // The program is a straight line of state numbers 1..10; an advance
   // moves to the next number. Watchdog is time-since-entry.
   int m_state = 0;
   int m_mode  = 1;
   int m_entry = 0;
   int m_cyc   = 0;
   bit m_hold  = 1'b0;

   always @(posedge clk) m_cyc <= m_cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         m_mode  <= 1;
         m_hold  <= 1'b0;
         m_entry <= m_cyc;
      end else begin
         int s, nxt, limit;
         bit adv;
         s     = m_state;
         nxt   = s;
         limit = (s == 2 || s == 6) ? FILL_T :
                 (s == 5 || s == 8 || s == 11) ? DRAIN_T : 0;
         case (s)
            2, 6:    adv = bus.water_full;
            3:       adv = bus.soaked;
            4:       adv = bus.washed;
            5, 8:    adv = bus.water_empty;
            7:       adv = bus.rinsed;
            9:       adv = bus.spun;
            default: adv = 1'b0;
         endcase
         if (limit != 0 && (m_cyc - m_entry) >= limit) nxt = 12;
         else if (bus.cancel && s >= 1 && s <= 9) nxt = 11;
         else if (s == 0) begin
            if (bus.start && bus.lid_closed && bus.mode != 2'b00) begin
               nxt = 1;
               m_mode <= int'(bus.mode);
            end
         end
         else if (s == 1) nxt = 2;
         else if (s >= 2 && s <= 9) begin
            if (adv) nxt = s + 1;
         end
         else if (s == 10) begin
            if (bus.start) nxt = 0;
         end
         else if (s == 11) begin
            if (bus.water_empty) nxt = 0;
         end
         if (nxt != s) m_entry <= m_cyc;
         m_state <= nxt;
         m_hold  <= (nxt == 3 || nxt == 4 || nxt == 7 || nxt == 9) &&
                    (bus.pause || !bus.lid_closed);
      end
   end

   function automatic logic [17:0] expv(int s, int md, bit h);
      logic [17:0] v;
      v        = '0;
      v[17:14] = 4'(s);
      v[13]    = (s == 0);
      v[12]    = (s == 1 && md == 1);
      v[11]    = (s == 1 && md == 2);
      v[10]    = (s == 1 && md == 3);
      v[9]     = (s == 3 && !h);
      v[8]     = (s == 4 && !h);
      v[7]     = (s == 7 && !h);
      v[6]     = (s == 9 && !h);
      v[5]     = (s == 2 || s == 6);
      v[4]     = (s == 5 || s == 8 || s == 11);
      v[3]     = (s >= 1 && s <= 9) || s == 11;
      v[2]     = (s == 10);
      v[1]     = (s == 12);
      v[0]     = h;
      return v;
   endfunction

   logic [17:0] dutv;
   assign dutv = {bus.state_o, bus.idle, bus.ready1, bus.ready2, bus.ready3,
                  bus.soak, bus.wash, bus.rinse, bus.spin, bus.fill_valve,
                  bus.drain_valve, bus.door_lock, bus.done, bus.fault, bus.paused};

   // Every-cycle compare, plus one line per finished/aborted wash cycle.
   initial begin
      int prev;
      prev = 0;
      forever begin
         @(negedge clk);
         checks++;
         if (dutv !== expv(m_state, m_mode, m_hold)) begin
            failures++;
            $display("FAIL cycle_compare t=%0t got=%b expected=%b",
                     $time, dutv, expv(m_state, m_mode, m_hold));
         end
         if (m_state != prev && (m_state == 10 || m_state == 11 || m_state == 12))
            $display("cycle end t=%0t state=%0d mode=%0d", $time, m_state, m_mode);
         prev = m_state;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start = 0; bus.mode = 2'b00; bus.pause = 0; bus.cancel = 0;
      bus.lid_closed = 1; bus.water_full = 0; bus.water_empty = 0;
      bus.soaked = 0; bus.washed = 0; bus.rinsed = 0; bus.spun = 0;
   endtask

   task automatic set_adv(int code, logic v);
      case (code)
         2, 6:    bus.water_full  = v;
         3:       bus.soaked      = v;
         4:       bus.washed      = v;
         5, 8:    bus.water_empty = v;
         7:       bus.rinsed      = v;
         9:       bus.spun        = v;
         default: ;
      endcase
   endtask

   task automatic pulse_adv(int code);
      set_adv(code, 1'b1);
      tick();
      set_adv(code, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   // From IDLE, start a cycle in mode md and advance straight to target.
   task automatic run_to(int target, logic [1:0] md);
      bus.mode = md; bus.start = 1;
      tick();
      bus.start = 0;
      tick();
      for (int c = 2; c < target; c++) pulse_adv(c);
      chk("run_to_state", int'(bus.state_o), target);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      clear_inputs();
      #1 rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      chk("reset_state", int'(bus.state_o), 0);
      chk("reset_idle", int'(bus.idle), 1);
      chk("reset_lock", int'(bus.door_lock), 0);

      // Full normal cycle, environment answering after 5 cycles.
      bus.mode = 2'b10; bus.start = 1;
      tick();
      bus.start = 0;
      chk("ready2_on", int'(bus.ready2), 1);
      chk("ready_state", int'(bus.state_o), 1);
      tick();
      chk("ready2_off", int'(bus.ready2), 0);
      chk("fill1_state", int'(bus.state_o), 2);
      for (int c = 2; c <= 9; c++) begin
         repeat (5) tick();
         chk("hold_state", int'(bus.state_o), c);
         pulse_adv(c);
         chk("step_state", int'(bus.state_o), c + 1);
      end
      chk("done_flag", int'(bus.done), 1);
      chk("done_unlock", int'(bus.door_lock), 0);
      bus.start = 1;
      tick();
      bus.start = 0;
      chk("done_to_idle", int'(bus.state_o), 0);
      $display("scenario normal_cycle complete");

      // Invalid mode / open lid keep IDLE.
      bus.mode = 2'b00; bus.start = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("mode0_idle", int'(bus.idle), 1);
      end
      bus.mode = 2'b01; bus.lid_closed = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("lidopen_state", int'(bus.state_o), 0);
      end
      bus.lid_closed = 1;
      tick();
      bus.start = 0;
      chk("ready1_on", int'(bus.ready1), 1);
      tick();
      chk("ready1_off", int'(bus.ready1), 0);
      bus.cancel = 1;
      tick();
      bus.cancel = 0;
      chk("cancel_fill_abort", int'(bus.state_o), 11);
      pulse_adv(5);
      chk("abort_to_idle", int'(bus.state_o), 0);
      $display("scenario start_gating complete");

      // Pause during WASH, then cancel during RINSE.
      run_to(4, 2'b11);
      bus.pause = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("pause_wash", int'(bus.wash), 0);
         chk("pause_flag", int'(bus.paused), 1);
         chk("pause_state", int'(bus.state_o), 4);
      end
      bus.pause = 0;
      tick();
      chk("resume_wash", int'(bus.wash), 1);
      chk("resume_flag", int'(bus.paused), 0);
      pulse_adv(4);
      chk("washed_drain1", int'(bus.state_o), 5);
      pulse_adv(5);
      pulse_adv(6);
      chk("rinse_state", int'(bus.state_o), 7);
      bus.cancel = 1;
      tick();
      bus.cancel = 0;
      chk("cancel_rinse", int'(bus.state_o), 11);
      chk("abort_drain", int'(bus.drain_valve), 1);
      chk("abort_rinse_off", int'(bus.rinse), 0);
      pulse_adv(11 - 6);
      chk("abort_idle", int'(bus.idle), 1);
      $display("scenario pause_cancel complete");

      // Cancel beats spun in SPIN.
      run_to(9, 2'b01);
      bus.cancel = 1; bus.spun = 1;
      tick();
      bus.cancel = 0; bus.spun = 0;
      chk("cancel_spun", int'(bus.state_o), 11);
      chk("cancel_spun_done", int'(bus.done), 0);
      pulse_adv(5);
      $display("scenario cancel_vs_spun complete");

      // Randomized run.
      for (int i = 0; i < 3000; i++) begin
         bus.start       = ($urandom_range(0, 3) == 0);
         bus.mode        = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
         bus.lid_closed  = ($urandom_range(0, 15) != 0);
         bus.cancel      = ($urandom_range(0, 59) == 0);
         bus.water_full  = ($urandom_range(0, 5) == 0);
         bus.water_empty = ($urandom_range(0, 5) == 0);
         bus.soaked      = ($urandom_range(0, 5) == 0);
         bus.washed      = ($urandom_range(0, 5) == 0);
         bus.rinsed      = ($urandom_range(0, 5) == 0);
         bus.spun        = ($urandom_range(0, 5) == 0);
         tick();
      end
      clear_inputs();
      do_reset();
      $display("scenario random complete");

      // Asynchronous reset in the middle of SPIN.
      run_to(9, 2'b10);
      chk("spin_on", int'(bus.spin), 1);
      chk("spin_lock", int'(bus.door_lock), 1);
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("arst_spin", int'(bus.spin), 0);
      chk("arst_lock", int'(bus.door_lock), 0);
      chk("arst_drain", int'(bus.drain_valve), 0);
      chk("arst_idle", int'(bus.idle), 1);
      tick();
      rst_n = 1;
      $display("scenario async_reset complete");

      // Fill watchdog.
      bus.mode = 2'b01; bus.start = 1;
      tick();
      bus.start = 0;
      tick();
      chk("wd_fill_entry", int'(bus.state_o), 2);
      repeat (FILL_T - 1) tick();
      chk("wd_before", int'(bus.state_o), 2);
      tick();
      chk("wd_fault_state", int'(bus.state_o), 12);
      chk("wd_fault_flag", int'(bus.fault), 1);
      chk("wd_fill_off", int'(bus.fill_valve), 0);
      bus.start = 1;
      repeat (5) tick();
      bus.start = 0;
      chk("fault_sticky", int'(bus.state_o), 12);
      do_reset();
      chk("fault_cleared", int'(bus.state_o), 0);
      $display("scenario watchdog complete");

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Top-level cycle controller for the automatic washing machine. It takes the user's start/mode/pause/cancel inputs and the water-level sensors, and drives the phase timer's `idle`, `ready1..3`, `soak`, `wash`, `rinse` and `spin` inputs. It advances on the timer's `soaked`, `washed`, `rinsed` and `spun` flags. It also owns the fill and drain valves, the door lock and fault detection.

## Interface
- `TMO_W`, 12: width of the fill/drain watchdog counter.
- `FILL_TIMEOUT`, 3000: maximum cycles in any fill state before fault.
- `DRAIN_TIMEOUT`, 2000: maximum cycles in any drain state before fault.
- `clk` in 1: system clock; every register updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: start request, level-sampled.
- `mode` in 2: wash program. 01 = short (ready1), 10 = normal (ready2), 11 = heavy (ready3), 00 = invalid.
- `pause` in 1: hold the current timed phase.
- `cancel` in 1: abort the running cycle.
- `lid_closed` in 1: lid sensor.
- `water_full`, `water_empty` in 1: level sensors.
- `soaked`, `washed`, `rinsed`, `spun` in 1: sticky done flags from the phase timer.
- `idle`, `ready1`, `ready2`, `ready3`, `soak`, `wash`, `rinse`, `spin` out 1: phase timer controls.
- `fill_valve`, `drain_valve`, `door_lock` out 1: actuators.
- `done`, `fault`, `paused` out 1: status.
- `state_o` out 4: current state encoding, for display.

## Operation
- States, with `state_o` encoding: IDLE 0, READY 1, FILL1 2, SOAK 3, WASH 4, DRAIN1 5, FILL2 6, RINSE 7, DRAIN2 8, SPIN 9, DONE 10, ABORT 11, FAULT 12.
- Output values per state:
  - IDLE: `idle`=1.
  - READY: exactly one of `ready1..3`=1, per the latched mode.
  - SOAK / WASH / RINSE / SPIN: the matching phase output =1, except while paused.
  - FILL1 / FILL2: `fill_valve`=1.
  - DRAIN1 / DRAIN2 / ABORT: `drain_valve`=1.
  - READY through SPIN, and ABORT: `door_lock`=1.
  - DONE: `done`=1.
  - FAULT: `fault`=1; all valves and phase outputs 0.
- Transitions:
  - IDLE→READY: `start`=1 && `lid_closed`=1 && `mode`≠00. `mode` is latched on this transition; later changes to `mode` are ignored until the next IDLE.
  - READY→FILL1: unconditionally, after one cycle.
  - FILL1→SOAK: `water_full`.
  - SOAK→WASH: `soaked`.
  - WASH→DRAIN1: `washed`.
  - DRAIN1→FILL2: `water_empty`.
  - FILL2→RINSE: `water_full`.
  - RINSE→DRAIN2: `rinsed`.
  - DRAIN2→SPIN: `water_empty`.
  - SPIN→DONE: `spun`.
  - DONE→IDLE: `start`=1. This does not begin a new cycle; a further `start` is needed.
- Pause:
  - In SOAK, WASH, RINSE or SPIN, `pause`=1 or `lid_closed`=0 forces all phase outputs to 0 and sets `paused`=1; the state is held.
  - The timer counters freeze because their phase inputs are low. The cycle resumes when pause clears.
  - Pause has no effect in fill or drain states.
- Cancel:
  - `cancel`=1 in any state from READY through SPIN goes to ABORT.
  - ABORT→IDLE on `water_empty`.
  - `cancel` is ignored in IDLE, DONE, ABORT and FAULT.
- Watchdog:
  - The counter clears on entry to any fill, drain or ABORT state and increments each cycle in that state.
  - Reaching `FILL_TIMEOUT` (fill states) or `DRAIN_TIMEOUT` (drain states, ABORT) → FAULT.
  - FAULT is left only via `rst_n`.
- Priority in a single cycle: watchdog expiry > `cancel` > normal advance > pause.

## Timing
- Moore outputs, registered: outputs change only on the edge where the state changes, never combinationally from inputs.
- Exception: the pause gating of the phase outputs and `paused` also take effect one edge after `pause`/`lid_closed` changes, i.e. they are registered too.
- Latency:
  - `start` sampled high at edge k → `ready*` high from edge k to edge k+1 → FILL1 from edge k+1.
  - A done flag or sensor sampled high at edge k moves the state at edge k.
- `idle` and `ready*` clear the timer. Each timed phase therefore begins with zeroed counters and cleared flags.
- Flags are sticky until the next `idle`/`ready*`, so the sequencer never re-uses a stale flag: each flag is consumed only in its own state.
- Async reset (`rst_n` low):
  - Immediately: state IDLE, `idle`=1.
  - All other outputs 0; watchdog 0; latched mode 01.
  - Reset mid-cycle drops all valves and the door lock at once.

## Test plan
- Reset, `mode`=10, `start` pulse, sensors and timer flags answered after 5 cycles each → `ready2` high for exactly 1 cycle. Then states step 2,3,4,5,6,7,8,9,10, and `done`=1 with `door_lock`=0.
- In IDLE with `mode`=00, or with `lid_closed`=0, `start`=1 for 10 cycles → stays in IDLE with `idle`=1. Then `mode`=01 → `ready1` pulses one cycle later.
- `pause`=1 for 20 cycles during WASH → `wash`=0 and `paused`=1 from the next edge, state stays 4. `pause`=0 → `wash`=1 again, and `washed` later advances to DRAIN1.
- `water_full` held 0 in FILL1 → `fault`=1 and `state_o`=12 after exactly `FILL_TIMEOUT` cycles, `fill_valve`=0. `start` is then ignored until `rst_n` pulses.
- `cancel` in RINSE → ABORT with `drain_valve`=1 and `rinse`=0. `water_empty` → IDLE with `idle`=1. `cancel` together with `spun` in SPIN → ABORT, not DONE.
- `rst_n` asserted low mid-SPIN, off clock edge → `spin`, `door_lock` and `drain_valve` drop to 0 and `idle` goes to 1 before the next edge.
